seq_bit_serializer: RTL and testbench

//   Upstream stimulus stage for the serial sequence detector.

---
 rtl/seq_bit_serializer.sv | 207 ++++++++++++++++++++
 tb/tb_seq_bit_serializer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_bit_serializer.sv
// -----------------------------------------------------------------------------
// seq_bit_serializer
//
// Purpose:
//   Stimulus source for the serial sequence detector. A parallel pattern and
//   its length are taken through a valid/ready load port. The pattern is then
//   played out MSB-first (bit [L-1] first, bit [0] last), one bit per clock, on
//   a registered serial output. Playback is one-shot or continuous-repeat, and
//   can be aborted synchronously with stop.
//
// Optional feature:
//   SEQ_PARITY_EN - when defined, every pass is followed by one extra cycle
//                   carrying the even-parity (XOR) bit of the L data bits.
//                   repeat_en is then sampled on that parity cycle. When
//                   undefined, a pass is exactly L cycles.
//
// Parameters:
//   WIDTH  maximum pattern length in bits (>= 2)
//   LEN_W  width of load_len; 2**LEN_W must exceed WIDTH
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   load_valid    in   pattern offered on load_data/load_len
//   load_ready    out  pattern can be accepted (IDLE only)
//   load_data     in   pattern, bit [len-1] sent first, bit [0] last
//   load_len      in   number of bits; 0 or > WIDTH selects WIDTH
//   repeat_en     in   sampled on the last cycle of each pass; 1 = replay
//   stop          in   synchronous abort (also blocks a load in IDLE)
//   serial_out    out  serial bit stream
//   serial_valid  out  serial_out carries a pattern bit this cycle
//   busy          out  high while shifting
//   done          out  one-cycle pulse after a non-repeated pass
// -----------------------------------------------------------------------------
module seq_bit_serializer #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  input  logic             repeat_en,
  input  logic             stop,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] pattern_reg, pattern_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic [LEN_W-1:0] idx_reg, idx_next;
  logic             out_reg, out_next;
  logic             valid_reg, valid_next;
`ifdef SEQ_PARITY_EN
  logic             par_phase_reg, par_phase_next;
  logic             parity_bit;
`endif

  // Effective length: 0 or anything above WIDTH means a full-width pattern.
  logic [LEN_W-1:0] eff_len;
  assign eff_len = ((load_len == '0) || (load_len > LEN_W'(WIDTH)))
                   ? LEN_W'(WIDTH) : load_len;

  // Bits above the effective length are zeroed on capture, so the stored
  // pattern holds only the L data bits and its XOR reduction is the parity.
  logic [WIDTH-1:0] load_mask;
  logic [WIDTH-1:0] load_masked;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
      assign load_mask[gi] = (LEN_W'(gi) < eff_len);
    end
  endgenerate

  assign load_masked = load_data & load_mask;

  // Bit selection by right shift keeps the index width independent of WIDTH.
  //   load_shifted   : first bit of a freshly loaded pattern
  //   replay_shifted : first bit of the stored pattern (repeat)
  //   step_shifted   : next lower bit during a pass
  logic [WIDTH-1:0] load_shifted;
  logic [WIDTH-1:0] replay_shifted;
  logic [WIDTH-1:0] step_shifted;

  assign load_shifted   = load_masked >> (eff_len - LEN_W'(1));
  assign replay_shifted = pattern_reg >> (len_reg - LEN_W'(1));
  assign step_shifted   = pattern_reg >> (idx_reg - LEN_W'(1));

`ifdef SEQ_PARITY_EN
  assign parity_bit = ^pattern_reg;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      pattern_reg   <= '0;
      len_reg       <= '0;
      idx_reg       <= '0;
      out_reg       <= 1'b0;
      valid_reg     <= 1'b0;
`ifdef SEQ_PARITY_EN
      par_phase_reg <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      pattern_reg   <= pattern_next;
      len_reg       <= len_next;
      idx_reg       <= idx_next;
      out_reg       <= out_next;
      valid_reg     <= valid_next;
`ifdef SEQ_PARITY_EN
      par_phase_reg <= par_phase_next;
`endif
    end
  end

  // Next-state and next-output logic. serial_out/serial_valid are computed
  // one cycle ahead and registered, so the bit chosen here appears on the
  // output during the cycle after the edge that selects it.
  always_comb begin
    state_next     = state_reg;
    pattern_next   = pattern_reg;
    len_next       = len_reg;
    idx_next       = idx_reg;
    out_next       = 1'b0;
    valid_next     = 1'b0;
`ifdef SEQ_PARITY_EN
    par_phase_next = par_phase_reg;
`endif

    case (state_reg)
      IDLE: begin
        // stop blocks a simultaneous load.
        if (load_valid && !stop) begin
          state_next     = SHIFT;
          pattern_next   = load_masked;
          len_next       = eff_len;
          idx_next       = eff_len - LEN_W'(1);
          out_next       = load_shifted[0];
          valid_next     = 1'b1;
`ifdef SEQ_PARITY_EN
          par_phase_next = 1'b0;
`endif
        end
      end

      SHIFT: begin
        if (stop) begin
          // Abort outranks both repeat and end-of-pass.
          state_next = IDLE;
        end else if (idx_reg != '0) begin
          idx_next   = idx_reg - LEN_W'(1);
          out_next   = step_shifted[0];
          valid_next = 1'b1;
        end else begin
          // Bit 0 is on the output now.
`ifdef SEQ_PARITY_EN
          if (!par_phase_reg) begin
            par_phase_next = 1'b1;
            out_next       = parity_bit;
            valid_next     = 1'b1;
          end else
`endif
          if (repeat_en) begin
            // Replay without a gap cycle.
            idx_next       = len_reg - LEN_W'(1);
            out_next       = replay_shifted[0];
            valid_next     = 1'b1;
`ifdef SEQ_PARITY_EN
            par_phase_next = 1'b0;
`endif
          end else begin
            state_next = DONE;
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // All outputs come straight from registers.
  assign serial_out   = out_reg;
  assign serial_valid = valid_reg;
  assign busy         = (state_reg == SHIFT);
  assign done         = (state_reg == DONE);
  assign load_ready   = (state_reg == IDLE);

endmodule

// File: tb/tb_seq_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_seq_bit_serializer
//
// Self-checking bench for seq_bit_serializer. Expected serial streams are
// built from the pattern/length rules (effective length, MSB-first order,
// optional XOR parity bit) and compared cycle by cycle, together with the
// busy/done/load_ready handshake, one-shot/repeat playback, abort, ignored
// busy loads and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_seq_bit_serializer;

  localparam int WIDTH = 8;
  localparam int LEN_W = 4;

  logic             clk;
  logic             rst_n;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic [LEN_W-1:0] load_len;
  logic             repeat_en;
  logic             stop;
  logic             serial_out;
  logic             serial_valid;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  bit pass_bits[$];

  seq_bit_serializer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_data    (load_data),
    .load_len     (load_len),
    .repeat_en    (repeat_en),
    .stop         (stop),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, ".serial_valid"}, 32'(serial_valid), 32'd0);
    chk({tag, ".serial_out"},   32'(serial_out),   32'd0);
    chk({tag, ".busy"},         32'(busy),         32'd0);
    chk({tag, ".done"},         32'(done),         32'd0);
    chk({tag, ".load_ready"},   32'(load_ready),   32'd1);
  endtask

  function automatic int eff_len(input int len);
    return (len == 0 || len > WIDTH) ? WIDTH : len;
  endfunction

  // Reference stream for one pass: bits L-1 .. 0, then the even-parity bit.
  task automatic build_pass(input logic [WIDTH-1:0] d, input int len);
    int l;
    int ones;
    l = eff_len(len);
    ones = 0;
    pass_bits.delete();
    for (int i = l - 1; i >= 0; i--) begin
      pass_bits.push_back(d[i]);
      ones += int'(d[i]);
    end
`ifdef SEQ_PARITY_EN
    pass_bits.push_back(bit'(ones % 2));
`endif
  endtask

  // Called at a falling edge with the block idle. Loads the pattern, plays
  // `passes` passes, optionally injects a busy-time load (cycle `inject`) or
  // a stop (cycle `stop_at`), and returns at a falling edge with the block
  // idle again, so another load can follow immediately.
  task automatic run(input string tag, input logic [WIDTH-1:0] d, input int len,
                     input int passes, input int stop_at, input int inject);
    int p_len;
    int total;
    int p;
    int k;
    build_pass(d, len);
    p_len = pass_bits.size();
    total = passes * p_len;
    $display("run %s data=%02h len=%0d passes=%0d stop_at=%0d inject=%0d",
             tag, d, len, passes, stop_at, inject);
    chk({tag, ".ready_before_load"}, 32'(load_ready), 32'd1);
    load_valid = 1'b1;
    load_data  = d;
    load_len   = LEN_W'(len);
    stop       = 1'b0;
    repeat_en  = 1'($urandom);
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      load_valid = 1'b0;
      p = c / p_len;
      k = c % p_len;
      chk($sformatf("%s.valid[%0d]", tag, c), 32'(serial_valid), 32'd1);
      chk($sformatf("%s.bit[%0d]", tag, c), 32'(serial_out), 32'(pass_bits[k]));
      chk($sformatf("%s.busy[%0d]", tag, c), 32'(busy), 32'd1);
      chk($sformatf("%s.ready[%0d]", tag, c), 32'(load_ready), 32'd0);
      chk($sformatf("%s.done[%0d]", tag, c), 32'(done), 32'd0);
      if (k == p_len - 1) repeat_en = (p < passes - 1);
      else                repeat_en = 1'($urandom);
      if (c == inject) begin
        load_valid = 1'b1;
        load_data  = 8'hFF;
        load_len   = LEN_W'($urandom);
      end
      if (c == stop_at) begin
        stop = 1'b1;
        @(negedge clk);
        stop       = 1'b0;
        load_valid = 1'b0;
        expect_idle({tag, ".after_stop"});
        return;
      end
    end
    @(negedge clk);
    load_valid = 1'b0;
    repeat_en  = 1'($urandom);
    chk({tag, ".done_pulse"},   32'(done),         32'd1);
    chk({tag, ".done_valid"},   32'(serial_valid), 32'd0);
    chk({tag, ".done_out"},     32'(serial_out),   32'd0);
    chk({tag, ".done_ready"},   32'(load_ready),   32'd0);
    chk({tag, ".done_busy"},    32'(busy),         32'd0);
    @(negedge clk);
    expect_idle({tag, ".back_idle"});
  endtask

  initial begin
    int len;
    int passes;
    int stop_at;
    int inject;
    int total;
    logic [WIDTH-1:0] d;

    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_len   = '0;
    repeat_en  = 1'b0;
    stop       = 1'b0;

    #12;
    expect_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_idle("post_reset");

    // Directed cases.
    run("oneshot_1011", 8'h0B, 4, 1, -1, -1);
    run("repeat_x3",    8'h0B, 4, 3, -1, -1);
    run("full_width",   8'hA5, 0, 1, -1, -1);
    run("len_over_w",   8'h3C, 12, 1, -1, -1);
    run("abort_bit2",   8'h0B, 4, 1, 1, -1);
    run("after_abort",  8'h0B, 4, 1, -1, -1);
    run("busy_load",    8'h0B, 4, 1, -1, 1);
    run("len2_repeat",  8'h02, 2, 2, -1, 0);

    // stop in IDLE blocks a simultaneous load.
    $display("step stop_blocks_load");
    load_valid = 1'b1;
    load_data  = 8'h0B;
    load_len   = 4'd4;
    stop       = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    stop       = 1'b0;
    expect_idle("stop_blocks_load");
    @(negedge clk);
    expect_idle("stop_blocks_load_2");

    // Asynchronous reset mid-pass: reset values before the next clock edge.
    $display("step async_reset");
    load_valid = 1'b1;
    load_data  = 8'hF0;
    load_len   = 4'd8;
    @(negedge clk);
    load_valid = 1'b0;
    chk("async_reset.pre_valid", 32'(serial_valid), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 expect_idle("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    expect_idle("async_reset_hold");
    @(negedge clk);
    expect_idle("async_reset_release");

    // Randomized patterns, lengths, pass counts, aborts and busy loads.
    for (int t = 0; t < 25; t++) begin
      d      = WIDTH'($urandom);
      len    = $urandom_range(0, 15);
      passes = $urandom_range(1, 3);
      build_pass(d, len);
      total  = passes * pass_bits.size();
      stop_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, total - 1) : -1;
      inject  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, total - 1) : -1;
      run($sformatf("rand%0d", t), d, len, passes, stop_at, inject);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
